clk_div_cfg_ctrl: RTL

Configuration sequencer for the integer clock divider. Accepts ratio/enable change requests over a valid/ready handshake and applies them glitch-safely: gate the divider, wait a settle window, load the new ratio, re-enable, and wait a lock window before reporting done. It sits in the reference-clock domain between the register file / system controller and the divider's `i_clk_en` and `i_div_ratio` inputs.

---
 rtl/clk_div_pkg.sv | 20 ++
 rtl/clk_div_seq_cnt.sv | 27 ++
 rtl/clk_div_cfg_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the clock-divider configuration sequencer.
// Holds the FSM state encoding, default parameters and the lock multiplier.
package clk_div_pkg;

    localparam int RATIO_W_DEF     = 8;
    localparam int RESET_RATIO_DEF = 1;
    localparam int SETTLE_CYC_DEF  = 2;

    // Lock window is this many divider ratios of ref-clock cycles.
    localparam int LOCK_MULT = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GATE,
        ST_SETTLE,
        ST_LOAD,
        ST_LOCK
    } state_t;

endpackage

// File: rtl/clk_div_seq_cnt.sv
// Loadable down-counter with zero flag, shared by the settle and lock waits.
// Ports: clk, rst_n, load/load_val, dec -> cnt, zero.
module clk_div_seq_cnt #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/clk_div_cfg_ctrl.sv
// Glitch-safe ratio/enable update sequencer for the integer clock divider:
// gate, settle, load, re-enable, lock. Request in via valid/ready; drives the
// divider ratio and enable; reports busy, locked, done and err pulses.
module clk_div_cfg_ctrl
    import clk_div_pkg::*;
#(
    parameter int RATIO_W     = RATIO_W_DEF,
    parameter int RESET_RATIO = RESET_RATIO_DEF,
    parameter int SETTLE_CYC  = SETTLE_CYC_DEF
) (
    input  logic               i_ref_clk,
    input  logic               i_rst_n,
    input  logic               i_req_valid,
    input  logic [RATIO_W-1:0] i_req_ratio,
    input  logic               i_req_en,
    output logic               o_req_ready,
    output logic [RATIO_W-1:0] o_div_ratio,
    output logic               o_clk_en,
    output logic               o_busy,
    output logic               o_locked,
    output logic               o_done,
    output logic               o_err
);

    localparam int CW = RATIO_W + 1;

    state_t             state, state_d;
    logic [RATIO_W-1:0] pend_ratio, pend_ratio_d;
    logic               pend_en, pend_en_d;
    logic [RATIO_W-1:0] ratio_d;
    logic               en_d;
    logic               locked_d;
    logic               done_d;
    logic               err_pend, err_pend_d;

    logic               cnt_load;
    logic [CW-1:0]      cnt_val;
    logic               cnt_dec;
    logic [CW-1:0]      cnt;
    logic               cnt_zero;

    logic [CW-1:0]      lock_val;

    // 2*ratio-1 in RATIO_W+1 bits: no overflow even at the maximum ratio.
    assign lock_val = CW'(LOCK_MULT) * {1'b0, pend_ratio} - CW'(1);

    clk_div_seq_cnt #(
        .W (CW)
    ) u_cnt (
        .clk      (i_ref_clk),
        .rst_n    (i_rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    assign o_req_ready = (state == ST_IDLE);
    assign o_busy      = (state != ST_IDLE);

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            pend_ratio  <= '0;
            pend_en     <= 1'b0;
            o_div_ratio <= RATIO_W'(RESET_RATIO);
            o_clk_en    <= 1'b0;
            o_locked    <= 1'b0;
            o_done      <= 1'b0;
            err_pend    <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            state       <= state_d;
            pend_ratio  <= pend_ratio_d;
            pend_en     <= pend_en_d;
            o_div_ratio <= ratio_d;
            o_clk_en    <= en_d;
            o_locked    <= locked_d;
            o_done      <= done_d;
            err_pend    <= err_pend_d;
            // Reject is reported one edge after the accept edge.
            o_err       <= err_pend;
        end
    end

    always_comb begin
        state_d      = state;
        pend_ratio_d = pend_ratio;
        pend_en_d    = pend_en;
        ratio_d      = o_div_ratio;
        en_d         = o_clk_en;
        locked_d     = o_locked;
        done_d       = 1'b0;
        err_pend_d   = 1'b0;
        cnt_load     = 1'b0;
        cnt_val      = '0;
        cnt_dec      = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (i_req_valid) begin
                    if (i_req_ratio == '0) begin
                        err_pend_d = 1'b1;
                    end else begin
                        pend_ratio_d = i_req_ratio;
                        pend_en_d    = i_req_en;
                        state_d      = ST_GATE;
                    end
                end
            end
            ST_GATE: begin
                en_d     = 1'b0;
                locked_d = 1'b0;
                cnt_load = 1'b1;
                cnt_val  = CW'(SETTLE_CYC - 1);
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_zero) begin
                    state_d = ST_LOAD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_LOAD: begin
                // Divider is gated here, so the ratio can change safely.
                ratio_d = pend_ratio;
                en_d    = pend_en;
                if (pend_en) begin
                    cnt_load = 1'b1;
                    cnt_val  = lock_val;
                    state_d  = ST_LOCK;
                end else begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_LOCK: begin
                if (cnt_zero) begin
                    locked_d = 1'b1;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
